// File: rtl/push_ingress_arbiter.sv
// push_ingress_arbiter: round-robin push arbiter with per-tree occupancy limits and global stall.
// Define PUSH_ARB_STATS_EN to add the o_push_cnt / o_stall_cnt statistics ports.
module push_ingress_arbiter #(
    parameter int PTW = 16,
    parameter int MTW = 0,
    parameter int TREE_NUM = 4,
    parameter int PORT_NUM = 4,
    parameter int TREE_CAP = 15,
    localparam int TREE_NUM_BITS = $clog2(TREE_NUM),
    localparam int OCC_W = $clog2(TREE_CAP + 1),
    localparam int DW = MTW + PTW,
    localparam int PW = $clog2(PORT_NUM)
) (
    input  logic                              i_clk,
    input  logic                              i_arst,
    input  logic [PORT_NUM-1:0]               i_in_valid,
    output logic [PORT_NUM-1:0]               o_in_ready,
    input  logic [PORT_NUM*TREE_NUM_BITS-1:0] i_in_tree_id,
    input  logic [PORT_NUM*DW-1:0]            i_in_data,
    output logic                              o_push,
    output logic [TREE_NUM_BITS-1:0]          o_push_tree_id,
    output logic [DW-1:0]                     o_push_data,
    input  logic                              i_task_fifo_full,
    input  logic                              i_pop_done,
    input  logic [TREE_NUM_BITS-1:0]          i_pop_tree_id,
    output logic [TREE_NUM-1:0]               o_tree_full,
    output logic                              o_occ_err
`ifdef PUSH_ARB_STATS_EN
    ,
    output logic [31:0]                       o_push_cnt,
    output logic [31:0]                       o_stall_cnt
`endif
);
    logic [PW-1:0]            rr_ptr;
    logic [PW-1:0]            gnt_idx;
    logic                     grant;
    logic                     pop_err;
    logic [PORT_NUM-1:0]      elig;
    logic [TREE_NUM_BITS-1:0] gnt_tree;
    logic [DW-1:0]            gnt_data;
    logic [TREE_NUM_BITS-1:0] port_tree [PORT_NUM];
    logic [OCC_W-1:0]         occ       [TREE_NUM];
    logic [OCC_W-1:0]         occ_nxt   [TREE_NUM];
    genvar p;
    generate
        for (p = 0; p < PORT_NUM; p++) begin : g_port
            assign port_tree[p] = i_in_tree_id[p*TREE_NUM_BITS +: TREE_NUM_BITS];
            assign elig[p] = i_in_valid[p] && (occ[port_tree[p]] < OCC_W'(TREE_CAP))
                             && !i_task_fifo_full && !i_arst;
        end
    endgenerate
    // First eligible port at or after rr_ptr, wrapping around the port list
    always_comb begin
        grant = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < PORT_NUM; k++)
            if (!grant && elig[(int'(rr_ptr) + k) % PORT_NUM]) begin
                grant = 1'b1;
                gnt_idx = PW'((int'(rr_ptr) + k) % PORT_NUM);
            end
    end
    always_comb begin
        o_in_ready = '0;
        if (grant)
            o_in_ready[gnt_idx] = 1'b1;
    end
    assign gnt_tree = port_tree[gnt_idx];
    assign gnt_data = i_in_data[int'(gnt_idx)*DW +: DW];
    // Pops on an empty tree never decrement; they only raise the sticky error
    always_comb begin
        pop_err = i_pop_done && (occ[i_pop_tree_id] == '0);
        for (int t = 0; t < TREE_NUM; t++)
            occ_nxt[t] = occ[t]
                + OCC_W'(grant && (gnt_tree == TREE_NUM_BITS'(t)))
                - OCC_W'(i_pop_done && (i_pop_tree_id == TREE_NUM_BITS'(t)) && (occ[t] != '0));
    end
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            o_push <= 1'b0;
            o_push_tree_id <= '0;
            o_push_data <= '0;
            rr_ptr <= '0;
            o_tree_full <= '0;
            o_occ_err <= 1'b0;
            for (int t = 0; t < TREE_NUM; t++)
                occ[t] <= '0;
        end else begin
            o_push <= grant;
            if (grant) begin
                o_push_tree_id <= gnt_tree;
                o_push_data <= gnt_data;
                rr_ptr <= (gnt_idx == PW'(PORT_NUM - 1)) ? '0 : gnt_idx + 1'b1;
            end
            for (int t = 0; t < TREE_NUM; t++) begin
                occ[t] <= occ_nxt[t];
                o_tree_full[t] <= (occ_nxt[t] == OCC_W'(TREE_CAP));
            end
            if (pop_err)
                o_occ_err <= 1'b1;
        end
    end
`ifdef PUSH_ARB_STATS_EN
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            o_push_cnt <= '0;
            o_stall_cnt <= '0;
        end else begin
            o_push_cnt <= o_push_cnt + 32'(o_push);
            o_stall_cnt <= o_stall_cnt + 32'((|i_in_valid) && !grant);
        end
    end
`endif
endmodule

// File: doc/push_ingress_arbiter.md
# push_ingress_arbiter

Ingress stage directly upstream of the task generator. It collects push requests from PORT_NUM independent sources, each carrying a target tree id and a rank word. Each cycle it round-robin selects at most one source and issues a single registered push to the generator. It tracks per-tree occupancy so no tree's PIFO is pushed beyond TREE_CAP, and it stalls globally while the generator's task FIFO reports full.

## Interface

- PTW, 16, priority/rank field width
- MTW, 0, metadata field width; push word is MTW+PTW bits
- TREE_NUM, 4, number of logical trees (power of two); TREE_NUM_BITS = $clog2(TREE_NUM)
- PORT_NUM, 4, number of ingress sources (2..16)
- TREE_CAP, 15, maximum entries outstanding per tree; OCC_W = $clog2(TREE_CAP+1)

Ports:

- i_clk, in, 1, sole clock
- i_arst, in, 1, asynchronous reset, active-high
- i_in_valid, in, PORT_NUM, per-port request valid
- o_in_ready, out, PORT_NUM, per-port grant; transfer occurs when valid&ready
- i_in_tree_id, in, PORT_NUM*TREE_NUM_BITS, per-port target tree; port p occupies slice [p*TREE_NUM_BITS +: TREE_NUM_BITS]
- i_in_data, in, PORT_NUM*(MTW+PTW), per-port push word, packed the same way
- o_push, out, 1, one-cycle push strobe to the generator
- o_push_tree_id, out, TREE_NUM_BITS, tree id qualified by o_push
- o_push_data, out, MTW+PTW, push word qualified by o_push
- i_task_fifo_full, in, 1, generator backpressure
- i_pop_done, in, 1, the generator completed one pop
- i_pop_tree_id, in, TREE_NUM_BITS, tree popped, qualified by i_pop_done
- o_tree_full, out, TREE_NUM, occ[t] == TREE_CAP
- o_occ_err, out, 1, sticky: a pop was reported on a tree with occ == 0

## Operation

- Eligibility: port p is eligible when i_in_valid[p]=1, occ[tree_id_p] < TREE_CAP, and i_task_fifo_full=0.
- Arbitration: combinational priority search starting at rr_ptr and wrapping modulo PORT_NUM. The first eligible port gets o_in_ready[p]=1. All other ready bits are 0, and at most one ready bit is high per cycle.
- o_in_ready may depend on i_in_valid. Sources must not make valid depend on ready. A source holds valid, tree id and data stable until it is granted.
- On a grant, at the clock edge:
  - the output register loads {1, tree_id_p, data_p};
  - rr_ptr is set to (p+1) mod PORT_NUM;
  - occ[tree_id_p] increments.
- With no grant, o_push is 0 at that edge and rr_ptr holds. Data and tree id outputs hold their previous values.
- Occupancy update per tree t, evaluated each edge: occ[t] += inc_t − dec_t, where
  - inc_t = grant to tree t;
  - dec_t = i_pop_done and i_pop_tree_id==t and occ[t]>0.
- Increment and decrement on the same tree in the same cycle leave occ unchanged.
- A pop on a tree with occ[t]==0 leaves occ at 0 and sets o_occ_err. o_occ_err clears only on reset.
- occ never exceeds TREE_CAP, because eligibility is checked against the pre-edge value.

## Timing

- Latency: a grant at edge n produces o_push=1 during cycle n+1, for exactly one cycle per grant. Back-to-back grants give a continuous o_push.
- Full is combinational into eligibility. No grant occurs in any cycle with i_task_fifo_full=1. The push already registered still issues; the generator must assert full with at least 1 entry of headroom.
- A pop decrement is visible to eligibility the cycle after i_pop_done.
- o_tree_full is registered, derived from occ, and updates the cycle after an occ change.
- Reset (asynchronous, any time) clears:
  - o_push, o_push_tree_id, o_push_data;
  - rr_ptr, all occ counters, o_occ_err.
- A push registered before reset is discarded. o_in_ready is all-0 while i_arst=1.

## Configuration

- PUSH_ARB_STATS_EN defined: adds two output ports.
  - o_push_cnt, 32-bit: increments on every o_push.
  - o_stall_cnt, 32-bit: increments each cycle in which some i_in_valid=1 but no grant occurs.
  - Both counters wrap at 2^32 and reset to 0.
- PUSH_ARB_STATS_EN undefined: these ports and counters do not exist, and all other behaviour is identical.

## Test plan

- Reset check: hold i_arst=1 with all valids high. Required: o_in_ready=0, o_push=0, o_tree_full=0, o_occ_err=0. After release, the first grant goes to port 0.
- Round-robin: all four ports valid, tree ids 1,2,3,1, data 0x1001..0x1004, no pops. Required:
  - grants in order 0,1,2,3,0,…;
  - o_push on consecutive cycles, each one cycle after its grant, with matching tree id and data.
- Capacity: only port 0 valid, tree 2, no pops. Required:
  - exactly 15 pushes, then o_tree_full[2]=1 and o_in_ready[0]=0;
  - one i_pop_done on tree 2 produces exactly one more push.
- Backpressure: i_task_fifo_full=1 for 5 cycles with ports valid. Required: zero grants during the window; at most 1 o_push, from a grant before the window; arbitration resumes at the saved rr_ptr.
- Simultaneous events: occ[1]=15, with a pop on tree 1 and a valid request for tree 1 in the same cycle. Required: no grant that cycle (occ is at TREE_CAP before the edge); a grant the next cycle; occ[1] ends at 15. Separately, a pop on tree 3 with occ 0 sets o_occ_err=1 and occ[3] stays 0.
- Mid-operation reset: assert i_arst during back-to-back pushes. Required:
  - o_push falls immediately;
  - all occ values are 0 after release;
  - with PUSH_ARB_STATS_EN defined, o_push_cnt reads 0.
